feedback_step_gen_v7: RTL and testbench
=======================================

Name: feedback_step_gen_v7

Overview:
Parametrised successor feedback step generator for the gyro closed loop. It integrates the demodulated error (or loads a constant step) on each trigger into a clamped accumulator. It then applies a programmable right-shift gain and saturates the result to the DAC step width. It sits between the error demodulator and the ramp/step DAC driver, and adds a hold mode, accumulator clamping, output saturation, synchronous clear and a valid strobe.

Parameters:
ERR_W, 32, error input width (signed); ERR_W <= ACC_W required
ACC_W, 32, accumulator / step_mon width (signed)
OUT_W, 16, output step width (signed); OUT_W <= ACC_W
SHIFT_W, 4, gain-select width; shift range 0..2^SHIFT_W-1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_trig  in  1  update strobe, one cycle per loop sample
i_err  in  ERR_W  signed error
i_gain_sel  in  SHIFT_W  arithmetic right-shift amount for output
i_fb_mode  in  2  0=off, 1=integrate, 2=const step, 3=hold
i_const_step  in  ACC_W  signed value loaded in const mode
i_step_max  in  ACC_W  signed accumulator upper clamp
i_step_min  in  ACC_W  signed accumulator lower clamp
i_clr  in  1  synchronous accumulator clear
o_step  out  OUT_W  signed shifted, saturated step
o_step_mon  out  ACC_W  accumulator value
o_valid  out  1  one-cycle pulse when o_step is refreshed after a trigger
o_sat  out  2  bit0 = accumulator clamp engaged on last update; bit1 = output saturation active
o_shift_idx  out  SHIFT_W  registered shift in use

Behaviour:
- Reset (async): err_r=0, trig_r=0, mode_r=0, acc=0, shift_idx=5 (truncated to SHIFT_W), o_step=0, o_valid=0, o_sat=0.
- Stage 0, edge k: err_r<=i_err; trig_r<=i_trig; mode_r<=i_fb_mode; shift_idx<=i_gain_sel.
- Stage 1, edge k+1. Priority: i_clr > mode_r.
  - i_clr=1: acc<=0, o_sat[0]<=0.
  - mode_r=0: acc<=0 every cycle, independent of trig_r; o_sat[0]<=0.
  - mode_r=3: acc and o_sat[0] held.
  - mode_r=1 and trig_r: sum = acc + sign-extended err_r, computed in ACC_W+1 bits with no wrap; acc<=clamp(sum).
  - mode_r=2 and trig_r: acc<=clamp(i_const_step).
  - Modes 1/2 with trig_r=0: hold.
- clamp(x) = i_step_max if x>i_step_max, else i_step_min if x<i_step_min, else x. i_step_max is compared first, so for misconfigured min>max any x>max gives max and all other x give min. o_sat[0]<=1 when a clamp is applied on that update, 0 otherwise.
- Stage 2, edge k+2: sh = acc >>> shift_idx (arithmetic).
  - o_step <= sh saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; o_sat[1] <= 1 when saturation occurs.
  - o_step and o_sat[1] update every cycle, so gain changes take effect without a trigger.
  - o_valid <= trig_r delayed one cycle. It pulses even in hold/off modes; i_clr does not suppress it.
- Latency: i_trig high in the cycle before edge k gives acc updated at edge k+1 and o_step/o_valid at edge k+2. o_step_mon = acc directly.
- Back-to-back triggers: each trigger produces its own update, no loss; o_valid pulses consecutively.
- Mode change takes effect on the next trigger via mode_r, except off (immediate zeroing one cycle after sampling).
- Reset mid-operation: all state returns to reset values immediately; no pending update survives.

Test Plan:
- Reset, then mode=1, gain=0, err=+100, 5 triggers spaced 4 cycles -> o_step_mon 100,200,...,500; o_step=500; o_valid 5 pulses each 2 edges after sampled trigger.
- mode=1, max=1000, min=-1000, err=+300, 5 triggers -> acc 300,600,900,1000,1000; o_sat[0]=1 on last two; then err=-3000 -> acc=-1000.
- mode=2, const_step=0x0001_0000, gain=0 -> o_step=32767, o_sat[1]=1; gain=1 with no trigger -> o_step still 32767; gain=2 -> o_step=16384, o_sat[1]=0.
- acc=-5 via integrate, gain=1 -> o_step=-3 (arithmetic shift); mode=3 with triggers and err=+50 -> acc stays -5, o_valid still pulses.
- i_clr and i_trig together in integrate mode, acc=700 -> acc=0 (clear wins); mode=0 with no trigger -> acc forced 0 next cycle.
- Assert i_rst_n low mid-integration (acc=12345, trigger in flight) -> acc, o_step, o_valid, o_sat immediately 0, o_shift_idx=5; no update after release.

Source files
------------

// File: rtl/feedback_step_gen_v7_if.sv
// Control/data bundle between the gyro loop error demodulator, the feedback step
// generator and the ramp/step DAC driver.
interface feedback_step_gen_v7_if #(
    parameter int ERR_W   = 32,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 4
);
    logic                      i_trig;
    logic signed [ERR_W-1:0]   i_err;
    logic        [SHIFT_W-1:0] i_gain_sel;
    logic        [1:0]         i_fb_mode;
    logic signed [ACC_W-1:0]   i_const_step;
    logic signed [ACC_W-1:0]   i_step_max;
    logic signed [ACC_W-1:0]   i_step_min;
    logic                      i_clr;
    logic signed [OUT_W-1:0]   o_step;
    logic signed [ACC_W-1:0]   o_step_mon;
    logic                      o_valid;
    logic        [1:0]         o_sat;
    logic        [SHIFT_W-1:0] o_shift_idx;

    modport master (
        output i_trig, i_err, i_gain_sel, i_fb_mode, i_const_step,
               i_step_max, i_step_min, i_clr,
        input  o_step, o_step_mon, o_valid, o_sat, o_shift_idx
    );

    modport slave (
        input  i_trig, i_err, i_gain_sel, i_fb_mode, i_const_step,
               i_step_max, i_step_min, i_clr,
        output o_step, o_step_mon, o_valid, o_sat, o_shift_idx
    );
endinterface

// File: rtl/feedback_step_gen_v7.sv
// Gyro closed-loop feedback step generator: clamped integrator / constant-step
// accumulator followed by a right-shift gain and saturation to the DAC step width.
module feedback_step_gen_v7 #(
    parameter int ERR_W   = 32,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    feedback_step_gen_v7_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_INT   = 2'd1,
        MODE_CONST = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    localparam logic [SHIFT_W-1:0]    SHIFT_RST = SHIFT_W'(5);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ERR_W-1:0]   err_reg;
    logic                      trig_reg;
    mode_e                     mode_reg;
    logic        [SHIFT_W-1:0] shift_reg;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic                      sat_acc_reg, sat_acc_next;
    logic                      trig_d_reg;
    logic                      valid_reg;
    logic signed [OUT_W-1:0]   step_reg, step_next;
    logic                      sat_out_reg, sat_out_next;

    // One extra bit keeps acc + err exact so the clamp sees the true sum.
    logic signed [ACC_W:0]     err_wide, acc_wide, sum_wide, cand_wide;
    logic signed [ACC_W:0]     max_wide, min_wide;
    logic signed [ACC_W-1:0]   clamped;
    logic                      clamp_hit;
    logic signed [ACC_W-1:0]   shifted;

    always_comb begin
        err_wide  = {{(ACC_W+1-ERR_W){err_reg[ERR_W-1]}}, err_reg};
        acc_wide  = {acc_reg[ACC_W-1], acc_reg};
        sum_wide  = acc_wide + err_wide;
        max_wide  = {bus.i_step_max[ACC_W-1], bus.i_step_max};
        min_wide  = {bus.i_step_min[ACC_W-1], bus.i_step_min};
        cand_wide = (mode_reg == MODE_CONST)
                  ? {bus.i_const_step[ACC_W-1], bus.i_const_step} : sum_wide;
        clamped   = cand_wide[ACC_W-1:0];
        clamp_hit = 1'b0;
        // Upper bound checked first so a min>max setup resolves deterministically.
        if (cand_wide > max_wide) begin
            clamped   = bus.i_step_max;
            clamp_hit = 1'b1;
        end else if (cand_wide < min_wide) begin
            clamped   = bus.i_step_min;
            clamp_hit = 1'b1;
        end
    end

    always_comb begin
        acc_next     = acc_reg;
        sat_acc_next = sat_acc_reg;
        if (bus.i_clr) begin
            acc_next     = '0;
            sat_acc_next = 1'b0;
        end else begin
            case (mode_reg)
                MODE_OFF: begin
                    acc_next     = '0;
                    sat_acc_next = 1'b0;
                end
                MODE_INT, MODE_CONST: begin
                    if (trig_reg) begin
                        acc_next     = clamped;
                        sat_acc_next = clamp_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output path runs every cycle so gain changes apply without a trigger.
    always_comb begin
        shifted      = acc_reg >>> shift_reg;
        step_next    = shifted[OUT_W-1:0];
        sat_out_next = 1'b0;
        if (shifted > OUT_MAX) begin
            step_next    = OUT_MAX[OUT_W-1:0];
            sat_out_next = 1'b1;
        end else if (shifted < OUT_MIN) begin
            step_next    = OUT_MIN[OUT_W-1:0];
            sat_out_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_reg     <= '0;
            trig_reg    <= 1'b0;
            mode_reg    <= MODE_OFF;
            shift_reg   <= SHIFT_RST;
            acc_reg     <= '0;
            sat_acc_reg <= 1'b0;
            trig_d_reg  <= 1'b0;
            valid_reg   <= 1'b0;
            step_reg    <= '0;
            sat_out_reg <= 1'b0;
        end else begin
            err_reg     <= bus.i_err;
            trig_reg    <= bus.i_trig;
            mode_reg    <= mode_e'(bus.i_fb_mode);
            shift_reg   <= bus.i_gain_sel;
            acc_reg     <= acc_next;
            sat_acc_reg <= sat_acc_next;
            trig_d_reg  <= trig_reg;
            valid_reg   <= trig_d_reg;
            step_reg    <= step_next;
            sat_out_reg <= sat_out_next;
        end
    end

    assign bus.o_step      = step_reg;
    assign bus.o_step_mon  = acc_reg;
    assign bus.o_valid     = valid_reg;
    assign bus.o_sat       = {sat_out_reg, sat_acc_reg};
    assign bus.o_shift_idx = shift_reg;
endmodule

// File: tb/tb_feedback_step_gen_v7.sv
// Directed vector bench for feedback_step_gen_v7: one table row per clock, plus
// hand-written reset and asynchronous mid-operation reset sequences.
module tb_feedback_step_gen_v7;
    logic i_clk = 1'b0;
    logic i_rst_n;

    feedback_step_gen_v7_if #(.ERR_W(32), .ACC_W(32), .OUT_W(16), .SHIFT_W(4)) bus ();

    feedback_step_gen_v7 #(.ERR_W(32), .ACC_W(32), .OUT_W(16), .SHIFT_W(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic               trig;
        logic signed [31:0] err;
        logic        [1:0]  mode;
        logic        [3:0]  gain;
        logic               clr;
        logic signed [31:0] cstep;
        logic signed [31:0] smax;
        logic signed [31:0] smin;
        logic signed [31:0] e_mon;
        logic signed [15:0] e_step;
        logic               e_valid;
        logic        [1:0]  e_sat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic signed [31:0] cur_max, cur_min, cur_const;

    function automatic void add(input logic trig, input int err, input logic [1:0] mode,
                                input logic [3:0] gain, input logic clr, input int mon,
                                input int step, input logic valid, input logic [1:0] sat);
        vec_t v;
        v.trig = trig; v.err = err; v.mode = mode; v.gain = gain; v.clr = clr;
        v.cstep = cur_const; v.smax = cur_max; v.smin = cur_min;
        v.e_mon = mon; v.e_step = 16'(step); v.e_valid = valid; v.e_sat = sat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic check_all(input string tag, input int mon, input int step,
                             input logic valid, input logic [1:0] sat, input int shift);
        check({tag, " mon"},   64'(bus.o_step_mon), 64'(mon));
        check({tag, " step"},  64'(bus.o_step),     64'(step));
        check({tag, " valid"}, 64'(bus.o_valid),    64'(valid));
        check({tag, " sat"},   64'(bus.o_sat),      64'(sat));
        check({tag, " shift"}, 64'(bus.o_shift_idx), 64'(shift));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Integrate +100 with gain 0, five triggers four cycles apart.
        cur_max = 1000000; cur_min = -1000000; cur_const = 0;
        for (int j = 0; j < 5; j++) begin
            add(1, 100, 1, 0, 0, 100*j,     100*j,     0, 0);
            add(0, 100, 1, 0, 0, 100*(j+1), 100*j,     0, 0);
            add(0, 100, 1, 0, 0, 100*(j+1), 100*(j+1), 1, 0);
            add(0, 100, 1, 0, 0, 100*(j+1), 100*(j+1), 0, 0);
        end
        // Off to zero, then back-to-back triggers into the +/-1000 clamp.
        cur_max = 1000; cur_min = -1000;
        add(0, 0,     0, 0, 0, 500,   500,   0, 0);
        add(0, 300,   1, 0, 0, 0,     500,   0, 0);
        add(0, 300,   1, 0, 0, 0,     0,     0, 0);
        add(1, 300,   1, 0, 0, 0,     0,     0, 0);
        add(1, 300,   1, 0, 0, 300,   0,     0, 0);
        add(1, 300,   1, 0, 0, 600,   300,   1, 0);
        add(1, 300,   1, 0, 0, 900,   600,   1, 0);
        add(1, 300,   1, 0, 0, 1000,  900,   1, 1);
        add(0, 300,   1, 0, 0, 1000,  1000,  1, 1);
        add(1, -3000, 1, 0, 0, 1000,  1000,  1, 1);
        add(0, -3000, 1, 0, 0, -1000, 1000,  0, 1);
        add(0, -3000, 1, 0, 0, -1000, -1000, 1, 1);
        add(0, -3000, 1, 0, 0, -1000, -1000, 0, 1);
        // Constant step 0x10000 and gain changes without a trigger.
        cur_max = 1000000; cur_min = -1000000; cur_const = 32'h0001_0000;
        add(1, 0, 2, 0, 0, -1000, -1000, 0, 1);
        add(0, 0, 2, 0, 0, 65536, -1000, 0, 0);
        add(0, 0, 2, 0, 0, 65536, 32767, 1, 2);
        add(0, 0, 2, 1, 0, 65536, 32767, 0, 2);
        add(0, 0, 2, 1, 0, 65536, 32767, 0, 2);
        add(0, 0, 2, 2, 0, 65536, 32767, 0, 2);
        add(0, 0, 2, 2, 0, 65536, 16384, 0, 0);
        // Clear, integrate -5, arithmetic shift, then hold ignores triggers.
        add(0, 0,  1, 2, 1, 0,  16384, 0, 0);
        add(1, -5, 1, 1, 0, 0,  0,     0, 0);
        add(0, -5, 1, 1, 0, -5, 0,     0, 0);
        add(0, -5, 1, 1, 0, -5, -3,    1, 0);
        add(1, 50, 3, 1, 0, -5, -3,    0, 0);
        add(1, 50, 3, 1, 0, -5, -3,    0, 0);
        add(0, 50, 3, 1, 0, -5, -3,    1, 0);
        add(0, 50, 3, 1, 0, -5, -3,    1, 0);
        add(0, 50, 3, 1, 0, -5, -3,    0, 0);
        // Reach 700, clear beats a pending trigger, then off zeroes at once.
        add(1, 705, 1, 0, 0, -5,  -3,  0, 0);
        add(0, 0,   1, 0, 0, 700, -5,  0, 0);
        add(1, 100, 1, 0, 0, 700, 700, 1, 0);
        add(1, 100, 1, 0, 1, 0,   700, 0, 0);
        add(0, 0,   1, 0, 0, 100, 0,   1, 0);
        add(0, 0,   0, 0, 0, 100, 100, 1, 0);
        add(0, 0,   0, 0, 0, 0,   100, 0, 0);
        add(0, 0,   0, 0, 0, 0,   0,   0, 0);
        // Negative output saturation, then min>max misconfiguration.
        cur_const = -100000;
        add(1, 0, 2, 0, 0, 0,       0,      0, 0);
        add(0, 0, 2, 0, 0, -100000, 0,      0, 0);
        add(0, 0, 2, 0, 0, -100000, -32768, 1, 2);
        add(1, 0, 2, 0, 0, -100000, -32768, 0, 2);
        cur_max = -10; cur_min = 10;
        add(0, 0, 2, 0, 0, 10,      -32768, 0, 3);
        cur_max = 1000000; cur_min = -1000000;
        add(0, 0, 2, 0, 0, 10,      10,     1, 1);

        i_rst_n = 1'b0;
        bus.i_trig = 1'b0; bus.i_err = '0; bus.i_gain_sel = '0; bus.i_fb_mode = '0;
        bus.i_const_step = '0; bus.i_step_max = 1000000; bus.i_step_min = -1000000;
        bus.i_clr = 1'b0;
        tick();
        tick();
        check_all("reset", 0, 0, 1'b0, 2'd0, 5);
        i_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.i_trig       = vecs[i].trig;
            bus.i_err        = vecs[i].err;
            bus.i_fb_mode    = vecs[i].mode;
            bus.i_gain_sel   = vecs[i].gain;
            bus.i_clr        = vecs[i].clr;
            bus.i_const_step = vecs[i].cstep;
            bus.i_step_max   = vecs[i].smax;
            bus.i_step_min   = vecs[i].smin;
            tick();
            $display("vec %0d: trig=%0d mode=%0d mon=%0d step=%0d valid=%0d sat=%0d",
                     i, vecs[i].trig, vecs[i].mode, bus.o_step_mon, bus.o_step,
                     bus.o_valid, bus.o_sat);
            check_all($sformatf("v%0d", i), vecs[i].e_mon, vecs[i].e_step,
                      vecs[i].e_valid, vecs[i].e_sat, vecs[i].gain);
        end

        // Build acc=12345 with gain 3, then reset with a trigger in flight.
        bus.i_trig = 1'b0; bus.i_fb_mode = 2'd0; bus.i_gain_sel = 4'd3;
        tick();
        tick();
        bus.i_fb_mode = 2'd1; bus.i_trig = 1'b1; bus.i_err = 12345;
        tick();
        bus.i_trig = 1'b0;
        tick();
        tick();
        $display("pre-reset: mon=%0d step=%0d", bus.o_step_mon, bus.o_step);
        check("pre-reset mon",  64'(bus.o_step_mon), 64'(12345));
        check("pre-reset step", 64'(bus.o_step),     64'(1543));
        bus.i_trig = 1'b1; bus.i_err = 1;
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        $display("async reset: mon=%0d step=%0d valid=%0d", bus.o_step_mon, bus.o_step,
                 bus.o_valid);
        check_all("async reset", 0, 0, 1'b0, 2'd0, 5);
        @(negedge i_clk);
        bus.i_trig = 1'b0;
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("post-reset %0d: mon=%0d valid=%0d", i, bus.o_step_mon, bus.o_valid);
            check($sformatf("post-reset %0d mon", i),   64'(bus.o_step_mon), 64'(0));
            check($sformatf("post-reset %0d valid", i), 64'(bus.o_valid),    64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
